// File: rtl/accel_ctrl_pkg.sv
// rtl/accel_ctrl_pkg.sv - shared states, opcodes, modes and command-byte layout
package accel_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ARB,
    ST_RD_SEND,
    ST_RD_WAIT,
    ST_COMPUTE,
    ST_WR_ARB,
    ST_WR_SEND,
    ST_WR_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  localparam logic [1:0] MODE_HASH   = 2'b00;
  localparam logic [1:0] MODE_STREAM = 2'b01;

  // Bit positions inside the command byte that sits above the address.
  localparam int CMD_ID_LSB   = 6;
  localparam int CMD_OP_LSB   = 4;
  localparam int CMD_LAST_BIT = 3;

  // Builds {id, op, last, 3'b000}.
  function automatic logic [7:0] cmd_byte(input logic [1:0] id, input logic [1:0] op,
                                          input logic last);
    logic [7:0] b;
    b                 = '0;
    b[CMD_ID_LSB +: 2] = id;
    b[CMD_OP_LSB +: 2] = op;
    b[CMD_LAST_BIT]    = last;
    return b;
  endfunction

  // Any mode with the upper bit set is reserved.
  function automatic logic mode_illegal(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/accel_ctrl_fsm_if.sv
// rtl/accel_ctrl_fsm_if.sv - request, completion and bus signals of the accelerator controller
interface accel_ctrl_fsm_if #(
  parameter int ADDRW = 24,
  parameter int LENW  = 4
);

  logic                      req_valid;
  logic [LENW+2+2*ADDRW-1:0] req_data;
  logic                      req_ready;

  logic                      compq_ready;
  logic                      compq_valid;
  logic [ADDRW-1:0]          compq_data;
  logic                      compq_err;

  logic                      arb_req;
  logic                      arb_grant;
  logic [2:0]                ack_in;
  logic [ADDRW+7:0]          data_out;
  logic                      data_valid;
  logic                      busy;

  // Controller side.
  modport master (
    input  req_valid, req_data, compq_ready, arb_grant, ack_in,
    output req_ready, compq_valid, compq_data, compq_err, arb_req, data_out, data_valid, busy
  );

  // Queue / bus / accelerator side.
  modport slave (
    output req_valid, req_data, compq_ready, arb_grant, ack_in,
    input  req_ready, compq_valid, compq_data, compq_err, arb_req, data_out, data_valid, busy
  );

endinterface

// File: rtl/ack_watchdog.sv
// rtl/ack_watchdog.sv - counts cycles spent waiting for an ack and flags expiry
module ack_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int TOW     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TOW-1:0] LIMIT = TOW'(TIMEOUT);

  logic [TOW-1:0] cnt;

  // Wait-cycle counter; restarts on entry to each wait state and saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + TOW'(1);
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expired = (TIMEOUT != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/accel_ctrl_fsm.sv
// rtl/accel_ctrl_fsm.sv - multi-block read/compute/write sequencer for one accelerator
module accel_ctrl_fsm
  import accel_ctrl_pkg::*;
#(
  parameter int         ADDRW     = 24,
  parameter logic [1:0] ACCEL_ID  = 2'b01,
  parameter int         LENW      = 4,
  parameter int         BLK_BYTES = 64,
  parameter int         TIMEOUT   = 1023,
  parameter int         TOW       = 10
) (
  input  logic              clk,
  input  logic              rst,
  accel_ctrl_fsm_if.master  bus
);

  localparam logic [ADDRW-1:0] STRIDE = ADDRW'(BLK_BYTES);

  state_t            state, state_nxt;
  logic [LENW-1:0]   idx, len_q;
  logic [1:0]        mode_q;
  logic [ADDRW-1:0]  src_q, dst_q;
  logic              err_q;

  logic [LENW-1:0]   req_len;
  logic [1:0]        req_mode;
  logic [ADDRW-1:0]  req_src, req_dst;

  logic              latch, idx_inc, set_timeout;
  logic              wd_clr, wd_en, wd_expired;
  logic              last_blk, is_stream, is_hash;
  logic [ADDRW-1:0]  blk_off, rd_addr, wr_addr;

  assign {req_len, req_mode, req_dst, req_src} = bus.req_data;

  assign last_blk  = (idx == len_q);
  assign is_stream = (mode_q == MODE_STREAM);
  assign is_hash   = (mode_q == MODE_HASH);
  // Offsets and sums deliberately truncate to ADDRW bits so addresses wrap.
  assign blk_off   = ADDRW'(idx) * STRIDE;
  assign rd_addr   = src_q + blk_off;
  assign wr_addr   = is_hash ? dst_q : (dst_q + blk_off);

  // The watchdog only runs while an ack is outstanding and restarts on each new wait.
  assign wd_en  = (state == ST_RD_WAIT) || (state == ST_COMPUTE) || (state == ST_WR_WAIT);
  assign wd_clr = (state_nxt != state) &&
                  ((state_nxt == ST_RD_WAIT) || (state_nxt == ST_COMPUTE) ||
                   (state_nxt == ST_WR_WAIT));

  ack_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TOW     (TOW)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latched request, block index and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      mode_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
    end else if (latch) begin
      len_q  <= req_len;
      mode_q <= req_mode;
      src_q  <= req_src;
      dst_q  <= req_dst;
      idx    <= '0;
      err_q  <= mode_illegal(req_mode);
    end else begin
      if (idx_inc) begin
        idx <= idx + LENW'(1);
      end
      if (set_timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state and Moore outputs; an expected ack always beats the watchdog.
  always_comb begin
    state_nxt       = state;
    latch           = 1'b0;
    idx_inc         = 1'b0;
    set_timeout     = 1'b0;
    bus.req_ready   = 1'b0;
    bus.compq_valid = 1'b0;
    bus.compq_data  = '0;
    bus.compq_err   = 1'b0;
    bus.arb_req     = 1'b0;
    bus.data_valid  = 1'b0;
    bus.data_out    = '0;
    bus.busy        = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          latch     = 1'b1;
          state_nxt = mode_illegal(req_mode) ? ST_DONE : ST_RD_ARB;
        end
      end

      ST_RD_ARB: begin
        bus.arb_req = 1'b1;
        if (bus.arb_grant) begin
          state_nxt = ST_RD_SEND;
        end
      end

      ST_RD_SEND: begin
        bus.arb_req    = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_out   = {cmd_byte(ACCEL_ID, OP_RD, last_blk), rd_addr};
        state_nxt      = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (bus.ack_in[0]) begin
          state_nxt = ST_COMPUTE;
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_nxt   = ST_DONE;
        end
      end

      ST_COMPUTE: begin
        if (bus.ack_in[1]) begin
          if (is_stream || last_blk) begin
            state_nxt = ST_WR_ARB;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ST_RD_ARB;
          end
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_nxt   = ST_DONE;
        end
      end

      ST_WR_ARB: begin
        bus.arb_req = 1'b1;
        if (bus.arb_grant) begin
          state_nxt = ST_WR_SEND;
        end
      end

      ST_WR_SEND: begin
        bus.arb_req    = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_out   = {cmd_byte(ACCEL_ID, OP_WR, last_blk), wr_addr};
        state_nxt      = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        if (bus.ack_in[2]) begin
          if (last_blk) begin
            state_nxt = ST_DONE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ST_RD_ARB;
          end
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_nxt   = ST_DONE;
        end
      end

      ST_DONE: begin
        bus.compq_valid = 1'b1;
        bus.compq_data  = dst_q;
        bus.compq_err   = err_q;
        if (bus.compq_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_accel_ctrl_fsm.sv
// tb/tb_accel_ctrl_fsm.sv - self-checking bench for the accelerator control FSM
module tb_accel_ctrl_fsm;

  localparam int ADDRW = 24;
  localparam int LENW  = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   dv_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accel_ctrl_fsm_if #(.ADDRW(ADDRW), .LENW(LENW)) bus ();

  accel_ctrl_fsm #(
    .ADDRW(ADDRW), .ACCEL_ID(2'b01), .LENW(LENW), .BLK_BYTES(64), .TIMEOUT(8), .TOW(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Expected command words and completions {err, dst}.
  logic [31:0] exp_cmd[$];
  logic [24:0] exp_comp[$];

  // Responder knobs.
  int grant_delay = 0;
  int ack1_delay  = 0;
  bit ack0_en     = 1'b1;
  bit ack1_en     = 1'b1;
  int comp_entry  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_cmd(input logic [1:0] op, input logic last,
                                         input logic [23:0] addr);
    return {2'b01, op, last, 3'b000, addr};
  endfunction

  // Request-level model: reads every block from src, writes per block (stream) or once
  // at the end (hash). stall_blk names a block whose compute ack never comes (-1: none).
  task automatic model_req(input int len, input logic [1:0] mode, input logic [23:0] src,
                           input logic [23:0] dst, input int stall_blk);
    logic [23:0] off;
    if (mode[1]) begin
      exp_comp.push_back({1'b1, dst});
      return;
    end
    for (int i = 0; i <= len; i++) begin
      off = 24'(i * 64);
      exp_cmd.push_back(mk_cmd(2'b01, i == len, src + off));
      if (i == stall_blk) begin
        exp_comp.push_back({1'b1, dst});
        return;
      end
      if (mode == 2'b01) exp_cmd.push_back(mk_cmd(2'b10, i == len, dst + off));
    end
    if (mode == 2'b00) exp_cmd.push_back(mk_cmd(2'b10, 1'b1, dst));
    exp_comp.push_back({1'b0, dst});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_req(input logic [3:0] len, input logic [1:0] mode,
                          input logic [23:0] src, input logic [23:0] dst);
    int n;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      step();
      n++;
    end
    check("req_ready_wait", bus.req_ready, 1'b1);
    bus.req_data  = {len, mode, dst, src};
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_cmd.size() != 0 || exp_comp.size() != 0 || bus.busy) && n < 500) begin
      step();
      n++;
    end
    check(name, (exp_cmd.size() == 0 && exp_comp.size() == 0 && !bus.busy), 1'b1);
  endtask

  // Compare process: every command and completion against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_vs_busy", bus.req_ready, !bus.busy);
        if (bus.data_valid) begin
          dv_count++;
          if (exp_cmd.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_cmd: got 0x%0h, expected no command", bus.data_out);
          end else begin
            check("cmd", bus.data_out, exp_cmd[0]);
            exp_cmd.delete(0);
          end
        end
        if (bus.compq_valid) begin
          if (exp_comp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_comp: got 0x%0h, expected no completion",
                     {bus.compq_err, bus.compq_data});
          end else begin
            check("comp", {bus.compq_err, bus.compq_data}, exp_comp[0]);
            if (bus.compq_ready) exp_comp.delete(0);
          end
        end
      end
    end
  end

  // Bus/accelerator responder.
  initial begin
    int  arb_cnt;
    int  comp_k;
    bit  rd_pend, wr_pend, comp_act;
    arb_cnt = 0; comp_k = 0; rd_pend = 0; wr_pend = 0; comp_act = 0;
    bus.arb_grant = 1'b0;
    bus.ack_in    = 3'b000;
    forever begin
      step();
      bus.arb_grant = 1'b0;
      bus.ack_in    = 3'b000;
      if (rst || !bus.busy) begin
        arb_cnt = 0; rd_pend = 0; wr_pend = 0; comp_act = 0;
      end else begin
        if (bus.arb_req && !bus.data_valid) begin
          if (arb_cnt >= grant_delay) begin
            bus.arb_grant = 1'b1;
            arb_cnt = 0;
          end else begin
            arb_cnt++;
          end
        end
        if (rd_pend && ack0_en) begin
          bus.ack_in[0] = 1'b1;
          rd_pend    = 0;
          comp_act   = 1;
          comp_k     = 0;
          comp_entry = cyc + 1;
        end else if (comp_act) begin
          if (ack1_en && comp_k == ack1_delay) begin
            bus.ack_in[1] = 1'b1;
            comp_act = 0;
          end else begin
            comp_k++;
          end
        end
        if (wr_pend) begin
          bus.ack_in[2] = 1'b1;
          wr_pend = 0;
        end
        if (bus.data_valid) begin
          if (bus.data_out[29:28] == 2'b01) rd_pend = 1;
          else wr_pend = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cnt, n, dv0;
    bit early;
    rst = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_data    = '0;
    bus.compq_ready = 1'b1;
    repeat (3) step();

    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_arb_req", bus.arb_req, 1'b0);
    check("rst_data_valid", bus.data_valid, 1'b0);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_compq", {bus.compq_valid, bus.compq_err, bus.compq_data}, 26'h0);
    rst = 1'b0;
    step();

    // HASH, three blocks.
    model_req(2, 2'b00, 24'h001000, 24'h002000, -1);
    check("model_hash_0", exp_cmd[0], 32'h50001000);
    check("model_hash_1", exp_cmd[1], 32'h50001040);
    check("model_hash_2", exp_cmd[2], 32'h58001080);
    check("model_hash_w", exp_cmd[3], 32'h68002000);
    send_req(4'd2, 2'b00, 24'h001000, 24'h002000);
    wait_idle("hash_done");

    // STREAM, two blocks.
    model_req(1, 2'b01, 24'h000100, 24'h000400, -1);
    check("model_strm_0", exp_cmd[0], 32'h50000100);
    check("model_strm_1", exp_cmd[1], 32'h60000400);
    check("model_strm_2", exp_cmd[2], 32'h58000140);
    check("model_strm_3", exp_cmd[3], 32'h68000440);
    dv0 = dv_count;
    send_req(4'd1, 2'b01, 24'h000100, 24'h000400);
    wait_idle("stream_done");
    check("stream_pulses", dv_count - dv0, 4);

    // Grant stalled for 20+ cycles, then compute ack withheld until timeout.
    grant_delay = 20;
    ack1_en     = 1'b0;
    model_req(0, 2'b00, 24'h003000, 24'h004000, 0);
    send_req(4'd0, 2'b00, 24'h003000, 24'h004000);
    cnt = 0; n = 0; early = 0;
    while (!bus.data_valid && n < 100) begin
      if (bus.arb_req) cnt++;
      if (bus.compq_valid) early = 1;
      step();
      n++;
    end
    check("arb_hold_cycles", cnt, 21);
    check("no_arb_timeout", early, 1'b0);
    n = 0;
    while (!bus.compq_valid && n < 60) begin
      step();
      n++;
    end
    check("wd_latency", cyc - comp_entry, 9);
    check("wd_err", bus.compq_err, 1'b1);
    wait_idle("wd_done");

    // Compute ack landing on the expiry cycle wins.
    grant_delay = 0;
    ack1_en     = 1'b1;
    ack1_delay  = 8;
    model_req(0, 2'b00, 24'h005000, 24'h006000, -1);
    send_req(4'd0, 2'b00, 24'h005000, 24'h006000);
    wait_idle("ack_wins_done");
    ack1_delay  = 0;

    // Illegal mode, completion held back.
    bus.compq_ready = 1'b0;
    dv0 = dv_count;
    model_req(0, 2'b10, 24'h000000, 24'h00ABCD, -1);
    send_req(4'd0, 2'b10, 24'h000000, 24'h00ABCD);
    check("illegal_valid", bus.compq_valid, 1'b1);
    check("illegal_data", {bus.compq_err, bus.compq_data}, 25'h100ABCD);
    for (int i = 0; i < 5; i++) begin
      check("illegal_no_arb", bus.arb_req, 1'b0);
      check("illegal_hold", {bus.compq_valid, bus.compq_err, bus.compq_data}, 26'h300ABCD);
      step();
    end
    bus.compq_ready = 1'b1;
    check("illegal_ready_low", bus.req_ready, 1'b0);
    step();
    check("illegal_ready_back", bus.req_ready, 1'b1);
    check("illegal_valid_gone", bus.compq_valid, 1'b0);
    check("illegal_no_cmds", dv_count - dv0, 0);

    // Source address wrap.
    model_req(1, 2'b00, 24'hFFFFC0, 24'h007000, -1);
    check("model_wrap_0", exp_cmd[0], 32'h50FFFFC0);
    check("model_wrap_1", exp_cmd[1], 32'h58000000);
    send_req(4'd1, 2'b00, 24'hFFFFC0, 24'h007000);
    wait_idle("wrap_done");

    // Reset while waiting for the read ack.
    ack0_en = 1'b0;
    model_req(0, 2'b00, 24'h008000, 24'h009000, -1);
    send_req(4'd0, 2'b00, 24'h008000, 24'h009000);
    n = 0;
    while (!bus.data_valid && n < 50) begin
      step();
      n++;
    end
    step();
    check("rdwait_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_arb_req", bus.arb_req, 1'b0);
    check("arst_req_ready", bus.req_ready, 1'b1);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_outs", {bus.data_valid, bus.compq_valid, bus.compq_err}, 3'b000);
    exp_cmd.delete();
    exp_comp.delete();
    step();
    rst = 1'b0;
    ack0_en = 1'b1;
    repeat (10) step();
    check("post_rst_idle", bus.req_ready, 1'b1);
    model_req(0, 2'b01, 24'h00A000, 24'h00B000, -1);
    send_req(4'd0, 2'b01, 24'h00A000, 24'h00B000);
    wait_idle("post_rst_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
